// File: rtl/icache_fetch_if.sv
// ---------------------------------------------------------------------------
// icache_fetch_if
// Refill bus between the instruction cache and the word-wide instruction
// memory. The cache is the master and the memory is the slave.
//   mem_req   : refill request, registered by the cache, held until mem_ack
//   mem_addr  : word-aligned byte address of the requested word
//   mem_rdata : returned word, meaningful only while mem_ack is high
//   mem_ack   : one-cycle acknowledge for the word at mem_addr
// ---------------------------------------------------------------------------
interface icache_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/icache_fetch.sv
// ---------------------------------------------------------------------------
// icache_fetch
// Direct-mapped, read-only instruction cache for the fetch stage. A hit
// returns the instruction combinationally; a miss stalls fetch (hitF=0) and
// refills the whole line with a WORDS-beat request/acknowledge burst.
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-low; clears state, valid bits and mem_req
//   pcF    : fetch byte address, bits [1:0] ignored
//   flush  : invalidate every line (pulse or level)
//   instrF : instruction for pcF, 0 when hitF=0
//   hitF   : instrF is valid this cycle; fetch stalls when low
//   mem    : refill bus (master side)
// ---------------------------------------------------------------------------
module icache_fetch #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pcF,
    input  logic                  flush,
    output logic [31:0]           instrF,
    output logic                  hitF,
    icache_fetch_if.master        mem
);

    localparam int unsigned OffBits  = $clog2(WORDS);
    localparam int unsigned IdxBits  = $clog2(LINES);
    localparam int unsigned LineBits = 30 - OffBits;
    localparam int unsigned TagBits  = LineBits - IdxBits;

    typedef enum logic {StIdle, StFill} stateT;

    stateT stateQ, stateD;

    // Lookup fields of the current fetch address.
    logic [OffBits-1:0] pcOff;
    logic [IdxBits-1:0] pcIdx;
    logic [TagBits-1:0] pcTag;
    logic               unusedPc;

    assign pcOff    = pcF[OffBits+1:2];
    assign pcIdx    = pcF[IdxBits+OffBits+1:OffBits+2];
    assign pcTag    = pcF[31:IdxBits+OffBits+2];
    assign unusedPc = ^pcF[1:0];

    // Storage: only the valid bits are reset.
    logic [LINES-1:0]   validQ;
    logic [TagBits-1:0] tagQ  [LINES];
    logic [31:0]        dataQ [LINES*WORDS];

    // Refill context, latched when a fill starts.
    logic [LineBits-1:0] lineQ;
    logic [OffBits-1:0]  countQ;
    logic [OffBits-1:0]  countInc;
    logic                poisonQ;
    logic                memReqQ;
    logic [31:0]         memAddrQ;
    logic [IdxBits-1:0]  fillIdx;
    logic [TagBits-1:0]  fillTag;

    assign fillIdx  = lineQ[IdxBits-1:0];
    assign fillTag  = lineQ[LineBits-1:IdxBits];
    assign countInc = countQ + OffBits'(1);

    logic lookupHit;
    logic startFill;
    logic ackBeat;
    logic lastBeat;

    assign lookupHit = validQ[pcIdx] && (tagQ[pcIdx] == pcTag);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: if (!lookupHit && !flush) stateD = StFill;
            StFill: if (lastBeat) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        hitF      = 1'b0;
        instrF    = '0;
        startFill = 1'b0;
        ackBeat   = 1'b0;
        lastBeat  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                // A flush in IDLE hides the hit for the cycle it clears the line.
                if (lookupHit && !flush) begin
                    hitF   = 1'b1;
                    instrF = dataQ[{pcIdx, pcOff}];
                end
                startFill = !lookupHit && !flush;
            end
            StFill: begin
                // mem_req is high for the whole FILL state, so any ack here counts.
                ackBeat  = mem.mem_ack;
                // WORDS is a power of two: the last beat is the all-ones count.
                lastBeat = mem.mem_ack && (&countQ);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ refill control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ   <= '0;
            lineQ    <= '0;
            countQ   <= '0;
            poisonQ  <= 1'b0;
            memReqQ  <= 1'b0;
            memAddrQ <= '0;
        end else begin
            if (startFill) begin
                lineQ    <= pcF[31:OffBits+2];
                countQ   <= '0;
                poisonQ  <= 1'b0;
                memReqQ  <= 1'b1;
                memAddrQ <= {pcF[31:OffBits+2], {(OffBits + 2){1'b0}}};
            end
            if (ackBeat) begin
                countQ   <= countInc;
                memAddrQ <= {lineQ, countInc, 2'b00};
                if (lastBeat) begin
                    memReqQ <= 1'b0;
                end
            end
            // A flush during a burst lets it finish but keeps the line invalid.
            if ((stateQ == StFill) && flush) begin
                poisonQ <= 1'b1;
            end
            if (flush) begin
                validQ <= '0;
            end else if (lastBeat && !poisonQ) begin
                validQ[fillIdx] <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------- tag/data arrays
    always_ff @(posedge clk) begin
        if (ackBeat) begin
            dataQ[{fillIdx, countQ}] <= mem.mem_rdata;
        end
        if (lastBeat) begin
            tagQ[fillIdx] <= fillTag;
        end
    end

    assign mem.mem_req  = memReqQ;
    assign mem.mem_addr = memAddrQ;

endmodule

// File: tb/tb_icache_fetch.sv
// ---------------------------------------------------------------------------
// tb_icache_fetch
// Directed bench for icache_fetch. Stimulus pushes expected refill addresses
// and expected lookup results into queues; a monitor on the falling edge pops
// and compares them when the DUT presents a refill beat or a probe is marked.
// Memory word at address a: {4'h0, a[15:4], 16'h0} | ((a[3:2]+1) * 8'h11).
// ---------------------------------------------------------------------------
module tb_icache_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pcF;
    logic        flush;
    logic [31:0] instrF;
    logic        hitF;

    icache_fetch_if bus ();

    icache_fetch #(
        .LINES(16),
        .WORDS(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pcF   (pcF),
        .flush (flush),
        .instrF(instrF),
        .hitF  (hitF),
        .mem   (bus)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] instr;
        logic        req;
    } probeT;

    int          vectors     = 0;
    int          miscompares = 0;
    int          waitCycles  = 0;
    logic        probe       = 1'b0;
    logic [31:0] expAddr [$];
    probeT       probeQ  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] low;
        low = {30'd0, a[3:2]} + 32'd1;
        return {4'h0, a[15:4], 16'h0} | (low * 32'h11);
    endfunction

    // Memory slave: acks each beat after waitCycles idle cycles.
    initial begin
        int waitCnt;
        waitCnt       = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                if (waitCnt < waitCycles) begin
                    bus.mem_ack = 1'b0;
                    waitCnt++;
                end else begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = memWord(bus.mem_addr);
                    waitCnt       = 0;
                end
            end else begin
                bus.mem_ack = 1'b0;
                waitCnt     = 0;
            end
        end
    end

    // Monitor: refill beats and marked probes.
    always @(negedge clk) begin
        if (reset && bus.mem_req) begin
            vectors++;
            if (hitF !== 1'b0) begin
                miscompares++;
                $display("FAIL hitDuringFill: hitF=%0b required 0", hitF);
            end
            vectors++;
            if (expAddr.size() == 0) begin
                miscompares++;
                $display("FAIL unexpectedReq: mem_addr=0x%08h, no request expected",
                         bus.mem_addr);
            end else begin
                // Also checks that mem_addr holds during wait cycles.
                if (bus.mem_addr !== expAddr[0]) begin
                    miscompares++;
                    $display("FAIL memAddr: got 0x%08h, required 0x%08h",
                             bus.mem_addr, expAddr[0]);
                end
                if (bus.mem_ack) void'(expAddr.pop_front());
            end
        end
        if (probe) begin
            probeT p;
            vectors++;
            if (probeQ.size() == 0) begin
                miscompares++;
                $display("FAIL probeUnderflow: no expectation queued");
            end else begin
                p = probeQ.pop_front();
                if (hitF !== p.hit || instrF !== p.instr || bus.mem_req !== p.req) begin
                    miscompares++;
                    $display("FAIL %s: got hit=%0b instr=0x%08h req=%0b, required hit=%0b instr=0x%08h req=%0b",
                             p.name, hitF, instrF, bus.mem_req, p.hit, p.instr, p.req);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
        flush = 1'b0;
    endtask

    task automatic probeHere(input string name, input logic hit, input logic [31:0] instr,
                             input logic req);
        probeT p;
        p.name  = name;
        p.hit   = hit;
        p.instr = instr;
        p.req   = req;
        probeQ.push_back(p);
        probe = 1'b1;
    endtask

    task automatic probeAt(input string name, input logic [31:0] pc, input logic hit,
                           input logic [31:0] instr);
        step();
        pcF = pc;
        probeHere(name, hit, instr, 1'b0);
    endtask

    task automatic expectFill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) expAddr.push_back(base + 32'(4 * i));
    endtask

    // Steps until the refill burst ends; leaves time in the first IDLE cycle.
    task automatic fillDone(input string name);
        int n;
        n = 0;
        step();
        while (bus.mem_req && n < 200) begin
            step();
            n++;
        end
        vectors++;
        if (bus.mem_req) begin
            miscompares++;
            $display("FAIL %s: mem_req=%0b after 200 cycles, required 0", name, bus.mem_req);
        end
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        pcF   = 32'h0040_0000;
        step();
        step();
        check("resetMemReq", {31'd0, bus.mem_req}, 32'd0);
        check("resetMemAddr", bus.mem_addr, 32'd0);
        check("resetHit", {31'd0, hitF}, 32'd0);
        check("resetInstr", instrF, 32'd0);

        // Cold miss, zero-wait memory: hit five cycles after the miss.
        expectFill(32'h0040_0000);
        step();
        reset = 1'b1;
        probeHere("coldMiss", 1'b0, 32'd0, 1'b0);
        repeat (4) step();
        probeAt("coldHitT5", 32'h0040_0000, 1'b1, 32'h0000_0011);
        probeAt("coldWord1", 32'h0040_0004, 1'b1, 32'h0000_0022);
        probeAt("coldWord2", 32'h0040_0008, 1'b1, 32'h0000_0033);
        probeAt("coldWord3", 32'h0040_000C, 1'b1, 32'h0000_0044);

        // Wait states: three idle cycles before every ack.
        waitCycles = 3;
        expectFill(32'h0040_0040);
        probeAt("waitMiss", 32'h0040_0040, 1'b0, 32'd0);
        fillDone("waitFill");
        waitCycles = 0;
        probeAt("waitWord0", 32'h0040_0040, 1'b1, 32'h0004_0011);
        probeAt("waitWord2", 32'h0040_0048, 1'b1, 32'h0004_0033);

        // Conflict on index 0.
        expectFill(32'h0040_0100);
        probeAt("conflictMiss", 32'h0040_0100, 1'b0, 32'd0);
        fillDone("conflictFill");
        probeAt("conflictHit", 32'h0040_0104, 1'b1, 32'h0010_0022);
        expectFill(32'h0040_0000);
        probeAt("evictedMiss", 32'h0040_0000, 1'b0, 32'd0);
        fillDone("evictedFill");
        probeAt("evictedHit", 32'h0040_0000, 1'b1, 32'h0000_0011);

        // Flush after two acks: burst completes, line stays invalid.
        expectFill(32'h0040_0200);
        probeAt("flushFillMiss", 32'h0040_0200, 1'b0, 32'd0);
        step();
        step();
        step();
        flush = 1'b1;
        fillDone("poisonedFill");
        check("poisonBeatsDone", expAddr.size(), 32'd0);
        expectFill(32'h0040_0200);
        probeHere("poisonedRefetch", 1'b0, 32'd0, 1'b0);
        fillDone("refetchFill");
        probeAt("refetchHit", 32'h0040_0200, 1'b1, 32'h0020_0011);
        expectFill(32'h0040_0040);
        probeAt("flushClearedAll", 32'h0040_0040, 1'b0, 32'd0);
        fillDone("line4Refill");
        probeAt("line4Hit", 32'h0040_0044, 1'b1, 32'h0004_0022);

        // Flush in IDLE: no hit that cycle, no fill, and the line is gone.
        step();
        pcF   = 32'h0040_0200;
        flush = 1'b1;
        probeHere("idleFlushCycle", 1'b0, 32'd0, 1'b0);
        expectFill(32'h0040_0200);
        probeAt("idleFlushMiss", 32'h0040_0200, 1'b0, 32'd0);
        fillDone("idleFlushRefill");
        probeAt("idleFlushRefillHit", 32'h0040_020C, 1'b1, 32'h0020_0044);

        // pcF change mid-fill: latched line finishes, then the new line fills.
        expectFill(32'h0040_0000);
        expectFill(32'h0040_0020);
        probeAt("pcChangeMiss", 32'h0040_0000, 1'b0, 32'd0);
        step();
        step();
        pcF = 32'h0040_0020;
        fillDone("pcChangeFirst");
        probeHere("pcChangeIdle", 1'b0, 32'd0, 1'b0);
        fillDone("pcChangeSecond");
        probeAt("pcChangeNewHit", 32'h0040_002C, 1'b1, 32'h0002_0044);
        probeAt("pcChangeOldHit", 32'h0040_0000, 1'b1, 32'h0000_0011);

        // Asynchronous reset in the middle of a fill.
        expectFill(32'h0040_0300);
        probeAt("resetFillMiss", 32'h0040_0300, 1'b0, 32'd0);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("asyncMemReq", {31'd0, bus.mem_req}, 32'd0);
        check("asyncHit", {31'd0, hitF}, 32'd0);
        pcF = 32'h0040_0000;
        expAddr.delete();
        expectFill(32'h0040_0000);
        step();
        step();
        reset = 1'b1;
        probeHere("postResetMiss", 1'b0, 32'd0, 1'b0);
        fillDone("postResetFill");
        probeAt("postResetHit", 32'h0040_0004, 1'b1, 32'h0000_0022);

        step();
        step();
        check("beatsOutstanding", expAddr.size(), 32'd0);
        check("probesOutstanding", probeQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache between the pipelined MIPS core's fetch stage and a slower word-wide instruction memory. Serves `instrF` for `pcF` combinationally on a hit. On a miss it raises a stall and refills the whole line through a request/acknowledge burst. The fetch-stage stall logic consumes `hitF`: `stallF = ~hitF`.

## Interface
- `LINES`, default 16: number of cache lines; power of two, ≥2.
- `WORDS`, default 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `pcF` in 32: fetch byte address. Bits [1:0] are ignored.
- `instrF` out 32: instruction word for `pcF`. Equals 0 when `hitF`=0.
- `hitF` out 1: `instrF` is valid this cycle. 0 means the core must stall fetch.
- `flush` in 1: invalidate all lines (one-cycle pulse or level).
- `mem_req` out 1: refill request to instruction memory.
- `mem_addr` out 32: word-aligned byte address of the requested word.
- `mem_rdata` in 32: returned word; sampled only when `mem_ack`=1.
- `mem_ack` in 1: one-cycle acknowledge that `mem_rdata` holds the word at `mem_addr`.

## Operation
- Address split (defaults): offset = `pcF[3:2]` (log2 WORDS bits); index = `pcF[7:4]` (log2 LINES bits); tag = all remaining upper bits (24 at defaults).
- Storage:
  - `valid[LINES]` and `tag[LINES]` flop arrays.
  - Data array of `LINES*WORDS` words, read asynchronously.
  - Only `valid` is reset; tag and data arrays are not reset.
- `hitF` = (state==IDLE) & `valid[index]` & (`tag[index]`==tag). `instrF` = data[index][offset] when hit, else 0.
- FSM states:
  - IDLE:
    - On a miss and `flush`=0: latch line base (`pcF` with offset and byte bits cleared) and index, set count=0, go to FILL.
    - Otherwise stay in IDLE.
  - FILL:
    - `mem_req`=1; `mem_addr` = line base + 4*count.
    - On `mem_ack`: write `mem_rdata` to data[idx][count] and increment count.
    - When count==WORDS-1 and `mem_ack`=1: write the tag, set valid (unless the fill is poisoned), go to IDLE.
- Handshake:
  - `mem_req` and `mem_addr` are registered outputs and hold stable until `mem_ack`.
  - `mem_req` stays high across all WORDS beats. The next address appears the cycle after each ack.
  - `mem_ack` while `mem_req`=0 is ignored.
  - The memory may insert any number of wait cycles.
- `pcF` changes during FILL are ignored. The latched line completes, and lookup resumes with the current `pcF` in IDLE.
- Flush:
  - In IDLE: all valid bits clear at the edge; `hitF` is 0 that cycle and no fill starts.
  - During FILL: all valid bits clear and the fill is marked poisoned. The burst completes (no abort), the line is not marked valid, and the FSM returns to IDLE.
  - Flush on the same cycle as the final ack: the line is not marked valid.
- Replacement: a refill overwrites the indexed line regardless of its prior contents.

## Timing
- Reset values: state=IDLE, all valid=0, count=0, `mem_req`=0, `mem_addr`=0, `hitF`=0, `instrF`=0.
- Hit latency: 0 cycles, combinational from `pcF`.
- Miss sequence, zero-wait memory, WORDS=4:
  - Miss seen in cycle t.
  - `mem_req`=1 in cycles t+1..t+4, with acks in the same cycles.
  - IDLE at t+5, where `hitF`=1.
  - Penalty is WORDS+1 cycles, plus any memory wait cycles.
- Reset asserted mid-FILL:
  - `mem_req` drops immediately (asynchronously).
  - The partially filled line stays invalid.
  - After reset release, the first fetch misses.

## Test plan
- Cold miss:
  - Stimulus: reset, release, `pcF`=0x00400000; memory returns 0x11,0x22,0x33,0x44 with zero wait.
  - Required: `mem_addr` = 0x00400000, 0x00400004, 0x00400008, 0x0040000C in consecutive cycles.
  - Required: `hitF`=1 with `instrF`=0x11 five cycles after the miss.
  - Required: then `pcF`=0x0040000C gives a hit with `instrF`=0x44 and no `mem_req`.
- Wait states:
  - Stimulus: `mem_ack` delayed 3 cycles per beat.
  - Required: `mem_addr` holds each value until its ack; `hitF` stays 0 throughout; line correct afterwards.
- Conflict:
  - Stimulus: fill 0x00400000, then fetch 0x00400100 (same index 0, different tag).
  - Required: miss and refill; the following fetch of 0x00400000 misses again.
- Flush:
  - Stimulus: pulse `flush` after two acks of a fill.
  - Required: the burst completes all 4 beats, but a refetch of the same PC misses.
  - Stimulus: flush in IDLE.
  - Required: a previously valid line misses.
- PC change during fill:
  - Stimulus: switch `pcF` to 0x00400020 mid-fill.
  - Required: the fill of 0x00400000 completes, then a new fill starts at 0x00400020.
- Async reset:
  - Stimulus: assert `reset` low between clock edges mid-FILL.
  - Required: `mem_req`=0 and `hitF`=0 immediately; all lines invalid.
